// File: rtl/gc_link_pkg.sv
// gc_link_pkg: shared definitions for the garbler-to-host link stage.
//   - record tag encodings emitted by the garbler
//   - header word field positions
//   - transmit state enum
//   - helpers: tag classification and frame length (words after header)
package gc_link_pkg;

  localparam logic [2:0] TAG_NONE = 3'b000;
  localparam logic [2:0] TAG_KEYS = 3'b001;
  localparam logic [2:0] TAG_GT   = 3'b010;
  localparam logic [2:0] TAG_MASK = 3'b011;
  localparam logic [2:0] TAG_RSVD = 3'b100;
  localparam logic [2:0] TAG_IN0  = 3'b101;
  localparam logic [2:0] TAG_IN1  = 3'b110;
  localparam logic [2:0] TAG_IN01 = 3'b111;

  // Header word: [31:29] tag, [28:24] LEN, [23:20] zero, [19:0] cid
  localparam int HDR_TAG_LSB = 29;
  localparam int HDR_LEN_LSB = 24;
  localparam int HDR_LEN_W   = 5;
  localparam int HDR_CID_W   = 20;

  typedef enum logic [2:0] {
    HDR  = 3'd0,
    IDX0 = 3'd1,
    DAT0 = 3'd2,
    IDX1 = 3'd3,
    DAT1 = 3'd4
  } tx_state_e;

  // True for tags that carry a record; 000 and 100 are idle/reserved.
  function automatic logic tag_is_record(input logic [2:0] tag);
    return (tag != TAG_NONE) && (tag != TAG_RSVD);
  endfunction

  // Number of words following the header for a given tag; kw = words per label.
  function automatic logic [HDR_LEN_W-1:0] frame_len(input logic [2:0] tag, input int kw);
    int n;
    case (tag)
      TAG_KEYS, TAG_MASK: n = 2 * kw;
      TAG_GT:             n = 2 * kw + 1;
      TAG_IN0, TAG_IN1:   n = kw + 1;
      TAG_IN01:           n = 2 * kw + 2;
      default:            n = 0;
    endcase
    return n[HDR_LEN_W-1:0];
  endfunction

endpackage

// File: rtl/gc_rec_fifo.sv
// gc_rec_fifo: synchronous first-word-fall-through FIFO of whole records.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (pointers only)
//   push, wdata write request and record; ignored when full unless popping
//   pop         remove head record; ignored when empty
//   rdata       head record, valid whenever empty is low
//   full, empty status
//   level       records currently buffered (0..DEPTH)
module gc_rec_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         wr_en;
  logic         rd_en;

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));

  // A simultaneous pop frees the slot being written, so a full FIFO still
  // accepts the push; the write lands on the slot the head is leaving.
  assign rd_en = pop & ~empty;
  assign wr_en = push & (~full | rd_en);

  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage is data only and is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gc_tx_packer.sv
// gc_tx_packer: captures tagged garbler records into a FIFO and serializes
// each into a framed stream of 32-bit words with valid/ready handshake.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   tag, cid              record type (000/100 ignored) and clock-cycle id
//   index0, index1        label/table indices
//   data0, data1          label payloads (K bits each)
//   tx_valid/tx_ready     stream handshake toward the host link
//   tx_data, tx_last      stream word and end-of-frame marker
//   overflow              sticky: a record was dropped on a full FIFO
//   drop_cnt              saturating count of dropped records
//   fifo_level            records currently buffered
module gc_tx_packer
  import gc_link_pkg::*;
#(
  parameter int S     = 20,
  parameter int K     = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2:0]               tag,
  input  logic [S-1:0]             cid,
  input  logic [S-1:0]             index0,
  input  logic [S-1:0]             index1,
  input  logic [K-1:0]             data0,
  input  logic [K-1:0]             data1,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic [31:0]              tx_data,
  output logic                     tx_last,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int KW = K / 32;
  localparam int BW = (KW > 1) ? $clog2(KW) : 1;
  localparam int RW = 3 + 3 * S + 2 * K;

  // Record layout {tag, cid, index0, index1, data0, data1}, data1 at LSB.
  localparam int D1_LSB  = 0;
  localparam int D0_LSB  = K;
  localparam int I1_LSB  = 2 * K;
  localparam int I0_LSB  = 2 * K + S;
  localparam int CID_LSB = 2 * K + 2 * S;
  localparam int TAG_LSB = 2 * K + 3 * S;

  logic [RW-1:0] head;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop;
  logic          fire;
  logic          drop;

  tx_state_e     state, state_nxt;
  logic [BW-1:0] beat, beat_nxt;
  logic          beat_last;

  logic [2:0]    h_tag;
  logic [S-1:0]  h_cid;
  logic [S-1:0]  h_idx0;
  logic [S-1:0]  h_idx1;
  logic [K-1:0]  h_data0;
  logic [K-1:0]  h_data1;
  logic [K-1:0]  d0_shift;
  logic [K-1:0]  d1_shift;
  logic [31:0]   hdr_word;

  // ---- capture: record FIFO ----
  assign push_req = tag_is_record(tag);

  gc_rec_fifo #(
    .W     (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .wdata ({tag, cid, index0, index1, data0, data1}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  assign drop = push_req & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // ---- serialize: head record fields and word selection ----
  assign h_tag   = head[TAG_LSB +: 3];
  assign h_cid   = head[CID_LSB +: S];
  assign h_idx0  = head[I0_LSB  +: S];
  assign h_idx1  = head[I1_LSB  +: S];
  assign h_data0 = head[D0_LSB  +: K];
  assign h_data1 = head[D1_LSB  +: K];

  assign hdr_word  = {h_tag, frame_len(h_tag, KW), 4'b0000, HDR_CID_W'(h_cid)};
  assign beat_last = (beat == BW'(KW - 1));

  // Shift the current beat's word up to the top so labels go MS word first.
  assign d0_shift = h_data0 << {beat, 5'd0};
  assign d1_shift = h_data1 << {beat, 5'd0};

  assign tx_valid = ~empty;
  assign fire     = tx_valid & tx_ready;
  assign pop      = fire & tx_last;

  always_comb begin
    tx_data = '0;
    tx_last = 1'b0;
    if (!empty) begin
      case (state)
        HDR:  tx_data = hdr_word;
        IDX0: tx_data = 32'(h_idx0);
        DAT0: begin
          tx_data = d0_shift[K-1 -: 32];
          tx_last = beat_last && (h_tag == TAG_IN0);
        end
        IDX1: tx_data = 32'(h_idx1);
        DAT1: begin
          tx_data = d1_shift[K-1 -: 32];
          tx_last = beat_last;
        end
        default: ;
      endcase
    end
  end

  // ---- frame FSM ----
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    if (fire) begin
      case (state)
        HDR: begin
          beat_nxt = '0;
          case (h_tag)
            TAG_GT, TAG_IN0, TAG_IN01: state_nxt = IDX0;
            TAG_IN1:                   state_nxt = IDX1;
            default:                   state_nxt = DAT0;
          endcase
        end
        IDX0: state_nxt = DAT0;
        DAT0: begin
          if (beat_last) begin
            beat_nxt = '0;
            case (h_tag)
              TAG_IN01: state_nxt = IDX1;
              TAG_IN0:  state_nxt = HDR;
              default:  state_nxt = DAT1;
            endcase
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
        IDX1: state_nxt = DAT1;
        DAT1: begin
          if (beat_last) begin
            beat_nxt  = '0;
            state_nxt = HDR;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
        default: begin
          state_nxt = HDR;
          beat_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= HDR;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

endmodule

// File: tb/tb_gc_tx_packer.sv
// tb_gc_tx_packer: directed self-checking bench for gc_tx_packer (DEPTH=4).
module tb_gc_tx_packer;

  localparam int S     = 20;
  localparam int K     = 128;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   tag;
  logic [S-1:0] cid;
  logic [S-1:0] index0;
  logic [S-1:0] index1;
  logic [K-1:0] data0;
  logic [K-1:0] data1;
  logic         tx_valid;
  logic         tx_ready;
  logic [31:0]  tx_data;
  logic         tx_last;
  logic         overflow;
  logic [15:0]  drop_cnt;
  logic [$clog2(DEPTH):0] fifo_level;

  int errors = 0;
  int checks = 0;

  logic [31:0] ew[$];
  logic        el[$];

  gc_tx_packer #(.S(S), .K(K), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tag        (tag),
    .cid        (cid),
    .index0     (index0),
    .index1     (index1),
    .data0      (data0),
    .data1      (data1),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_data    (tx_data),
    .tx_last    (tx_last),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [31:0] w, input logic l);
    ew.push_back(w);
    el.push_back(l);
  endtask

  task automatic add_label(input logic [127:0] d, input logic last);
    logic [127:0] t;
    t = d;
    for (int j = 0; j < 4; j++) add(t[127-32*j -: 32], last && (j == 3));
  endtask

  // Expects one word per cycle with tx_ready already high.
  task automatic run_words(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      chk($sformatf("valid[%0d]", i), 64'(tx_valid), 64'd1);
      chk($sformatf("data[%0d]", i),  64'(tx_data),  64'(ew[i]));
      chk($sformatf("last[%0d]", i),  64'(tx_last),  64'(el[i]));
      tick();
      tag = 3'b000;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    tag      = 3'b000;
    cid      = '0;
    index0   = '0;
    index1   = '0;
    data0    = '0;
    data1    = '0;
    tx_ready = 1'b0;

    // Reset held with records offered: nothing captured.
    for (int i = 0; i < 4; i++) begin
      tag   = (i % 2 == 0) ? 3'b111 : 3'b000;
      cid   = 20'(i);
      data0 = {4{32'hDEADBEEF}};
      tick();
      chk("rst_valid", 64'(tx_valid), 64'd0);
      chk("rst_level", 64'(fifo_level), 64'd0);
    end
    chk("rst_data", 64'(tx_data), 64'd0);
    chk("rst_last", 64'(tx_last), 64'd0);
    chk("rst_ovf",  64'(overflow), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    tag   = 3'b000;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", 64'(tx_valid), 64'd0);
    chk("post_rst_level", 64'(fifo_level), 64'd0);

    // Keys frame, words written out by hand.
    tx_ready = 1'b1;
    tag   = 3'b001;
    cid   = 20'd0;
    data0 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    data1 = 128'h11112222_33334444_55556666_77778888;
    tick();
    tag = 3'b000;
    ew.delete(); el.delete();
    add(32'h28000000, 0);
    add(32'h01234567, 0); add(32'h89ABCDEF, 0); add(32'hFEDCBA98, 0); add(32'h76543210, 0);
    add(32'h11112222, 0); add(32'h33334444, 0); add(32'h55556666, 0); add(32'h77778888, 1);
    run_words(0, 8);
    chk("keys_level", 64'(fifo_level), 64'd0);
    chk("keys_idle",  64'(tx_valid), 64'd0);

    // Garbled table frame.
    tag    = 3'b010;
    cid    = 20'd3;
    index0 = 20'd6;
    index1 = 20'd7;
    data0  = 128'hA0A0A0A0_A1A1A1A1_A2A2A2A2_A3A3A3A3;
    data1  = 128'hB0B0B0B0_B1B1B1B1_B2B2B2B2_B3B3B3B3;
    tick();
    tag = 3'b000;
    ew.delete(); el.delete();
    add(32'h49000003, 0);
    add(32'h00000006, 0);
    add_label(data0, 0);
    add_label(data1, 1);
    run_words(0, 9);
    chk("gt_level", 64'(fifo_level), 64'd0);

    // Both-inputs frame, then a tag=101 record pushed one cycle later.
    tag    = 3'b111;
    cid    = 20'd1;
    index0 = 20'd2;
    index1 = 20'd3;
    data0  = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
    data1  = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
    tick();
    ew.delete(); el.delete();
    add(32'hEA000001, 0);
    add(32'h00000002, 0);
    add_label(128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3, 0);
    add(32'h00000003, 0);
    add_label(128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3, 1);
    tag    = 3'b101;
    cid    = 20'h00ABC;
    index0 = 20'h00044;
    data0  = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;
    data1  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
    add(32'hA5000ABC, 0);
    add(32'h00000044, 0);
    add_label(128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3, 1);
    run_words(0, 16);
    chk("both_level", 64'(fifo_level), 64'd0);

    // Backpressure in the middle of DAT0.
    tag   = 3'b001;
    cid   = 20'h12345;
    data0 = 128'h10203040_50607080_90A0B0C0_D0E0F000;
    data1 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    tick();
    tag = 3'b000;
    ew.delete(); el.delete();
    add(32'h28012345, 0);
    add_label(data0, 0);
    add_label(data1, 1);
    run_words(0, 1);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(tx_valid), 64'd1);
      chk("bp_data",  64'(tx_data),  64'(ew[2]));
      chk("bp_last",  64'(tx_last),  64'd0);
      tick();
    end
    tx_ready = 1'b1;
    run_words(2, 8);
    chk("bp_level", 64'(fifo_level), 64'd0);

    // Tag 110: index1 then data1.
    tag    = 3'b110;
    cid    = 20'd5;
    index0 = 20'd8;
    index1 = 20'd9;
    data0  = 128'h55555555_55555555_55555555_55555555;
    data1  = 128'h66666666_77777777_88888888_99999999;
    tick();
    tag = 3'b000;
    ew.delete(); el.delete();
    add(32'hC5000005, 0);
    add(32'h00000009, 0);
    add_label(128'h66666666_77777777_88888888_99999999, 1);
    run_words(0, 5);

    // Overflow: six records into a four-deep FIFO with the link stalled.
    tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tag    = 3'b101;
      cid    = 20'(i);
      index0 = 20'(16 + i);
      data0  = {32'hD0D0D0D0, 64'd0, 32'(i)};
      tick();
    end
    tag = 3'b000;
    chk("ovf_level", 64'(fifo_level), 64'd4);
    chk("ovf_flag",  64'(overflow),   64'd1);
    chk("ovf_drops", 64'(drop_cnt),   64'd2);
    chk("ovf_hdr",   64'(tx_data),    64'hA5000000);
    ew.delete(); el.delete();
    add(32'hA5000000, 0);
    add(32'h00000010, 0);
    add(32'hD0D0D0D0, 0); add(32'h00000000, 0); add(32'h00000000, 0); add(32'h00000000, 1);
    tx_ready = 1'b1;
    run_words(0, 4);
    // Push on the same edge as the final-word pop of a full FIFO.
    tag    = 3'b101;
    cid    = 20'd6;
    index0 = 20'd22;
    data0  = {32'hD0D0D0D0, 64'd0, 32'd6};
    chk("pp_valid", 64'(tx_valid), 64'd1);
    chk("pp_data",  64'(tx_data),  64'h00000000);
    chk("pp_last",  64'(tx_last),  64'd1);
    tick();
    tag = 3'b000;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_drops", 64'(drop_cnt),   64'd2);
    chk("pp_next",  64'(tx_data),    64'hA5000001);
    chk("pp_ovf",   64'(overflow),   64'd1);

    // Asynchronous reset mid-frame clears everything.
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(tx_valid),   64'd0);
    chk("mid_rst_data",  64'(tx_data),    64'd0);
    chk("mid_rst_last",  64'(tx_last),    64'd0);
    chk("mid_rst_ovf",   64'(overflow),   64'd0);
    chk("mid_rst_drop",  64'(drop_cnt),   64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mid_rst_idle", 64'(tx_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gc_tx_packer.md
# gc_tx_packer

Downstream link stage for the garbler. Captures every tagged record the garbler emits (keys, input labels, garbled tables, output masks), buffers whole records in a small FIFO, and serializes each one into a framed stream of 32-bit words with valid/ready handshaking toward the host link. The garbler has no backpressure input, so the block absorbs bursts and flags any record it has to drop.

## Interface
- S, 20: index/cid width; S ≤ 20 is required for the header format.
- K, 128: label width; must be a multiple of 32. KW = K/32 words per label.
- DEPTH, 16: record FIFO entries; must be a power of 2, ≥ 2.
- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset asynchronous and active-low
- tag  in  3  record type from the garbler; 000 and 100 are ignored
- cid  in  S  clock-cycle id of the record
- index0, index1  in  S  label/table indices
- data0, data1  in  K  payloads
- tx_valid  out  1  word available
- tx_ready  in  1  consumer accepts the word
- tx_data  out  32  stream word
- tx_last  out  1  final word of a frame
- overflow  out  1  sticky; a record was dropped
- drop_cnt  out  16  dropped records, saturating at 0xFFFF
- fifo_level  out  $clog2(DEPTH)+1  records buffered

## Operation
- Push: on a posedge where tag ∉ {000, 100}, the record {tag, cid, index0, index1, data0, data1} is written to the FIFO if not full. If full and no pop occurs that edge, the record is dropped, overflow ← 1, and drop_cnt increments.
- Frame words, in order:
  - Header: [31:29]=tag, [28:24]=LEN (words that follow), [23:20]=0, [19:0]=cid zero-extended.
  - Tag 001 (keys) and 011 (masks): header, data0, data1. LEN = 2·KW.
  - Tag 010 (garbled table): header, index0, data0, data1. LEN = 2·KW+1. index1 = index0+1 is implied and not sent.
  - Tag 101: header, index0, data0. LEN = KW+1.
  - Tag 110: header, index1, data1. LEN = KW+1.
  - Tag 111: header, index0, data0, index1, data1. LEN = 2·KW+2.
- Index words are zero-extended. Labels are sent MS word first (data[K-1:K-32] first).
- State machine, with a beat counter of $clog2(KW) bits:
  - HDR is the resting state; tx_valid = ~empty.
  - Header accepted → IDX0 (tags 010, 101, 111), IDX1 (tag 110), or DAT0 (tags 001, 011).
  - IDX0 → DAT0.
  - DAT0 runs KW beats, then → DAT1 (tags 001, 010, 011), IDX1 (tag 111), or HDR (tag 101).
  - IDX1 → DAT1.
  - DAT1 runs KW beats, then → HDR.
- Pop: the FIFO head is popped on the handshake of the tx_last word.
- State and beat counter advance only on tx_valid & tx_ready.

## Timing
- Reset (rst_n low, asynchronous): FIFO empty, state HDR, beat counter 0. tx_valid=0, tx_last=0, tx_data=0, overflow=0, drop_cnt=0, fifo_level=0. A reset mid-frame discards that frame and all buffered records.
- Latency: a record pushed at edge N makes tx_valid high in the cycle after N when the FIFO was empty. The FIFO is first-word-fall-through.
- tx_data and tx_last are driven combinationally from the FIFO head, state, and beat counter. They must stay stable while tx_valid & ~tx_ready.
- Push and pop on the same edge, FIFO full: the push is accepted and fifo_level is unchanged.
- Push and pop on the same edge, FIFO holding one record: the FIFO is not empty afterwards, and the next header follows with no bubble.
- Throughput: one word per cycle when tx_ready=1. Back-to-back frames have no idle cycle between them.
- drop_cnt saturates at 0xFFFF. overflow is cleared only by reset.

## Structure
- Package gc_link_pkg holds:
  - Tag constants: TAG_NONE, TAG_KEYS=001, TAG_GT=010, TAG_MASK=011, TAG_IN0=101, TAG_IN1=110, TAG_IN01=111.
  - Header field positions.
  - The state enum {HDR, IDX0, DAT0, IDX1, DAT1}.
  - A LEN-from-tag function.
- Sub-module gc_rec_fifo: parameterized-width synchronous FWFT FIFO with push, pop, full, empty, and level. The FSM, serializer, and counters live in gc_tx_packer.

## Test plan
- Reset: hold rst_n=0 with tag=111 toggling → all outputs 0 and nothing is captured. Release rst_n → tx_valid stays 0.
- Keys: tag=001, cid=0, tx_ready=1 → 9 words. Word 0 = 0x28000000; next 4 words = data0 MS word first; then data1; tx_last only on word 9; fifo_level returns to 0.
- Garbled table: tag=010, cid=3, index0=6 → 0x49000003, 0x00000006, data0 ×4, data1 ×4; tx_last on word 10.
- Both inputs: tag=111, cid=1, index0=2, index1=3 → 0xEA000001, 0x00000002, data0 ×4, 0x00000003, data1 ×4 (11 words). A tag=101 record pushed one cycle later starts on the very next cycle with 0xA5000000 | cid.
- Backpressure: drop tx_ready for 5 cycles mid-DAT0 → tx_data and tx_last hold their values; the frame completes intact afterward.
- Overflow (DEPTH=4): tx_ready=0, push 6 tag=101 records → fifo_level=4, overflow=1, drop_cnt=2. Then set tx_ready=1 and push on the edge of a final-word pop → push accepted, fifo_level stays 4.
